im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Write-side counterpart of the combinational instruction ROM lookup (addr[9:0] -> chu[31:0]).
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into an internal register-array instruction memory at incrementing word addresses.
- Exposes the same asynchronous read port (addr -> chu), so the CPU fetch path reads back the loaded program.

Parameters:
ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words (default 1024).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  load request; sampled only in IDLE or DONE.
len  input  ADDR_W+1  number of words to load; sampled with start.
byte_in  input  8  stream data byte.
byte_valid  input  1  byte_in is valid this cycle.
byte_ready  output  1  loader accepts a byte this cycle.
addr  input  ADDR_W  read word address.
chu  output  32  mem[addr], combinational.
busy  output  1  high while in LOAD.
done  output  1  high in DONE.
word_count  output  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset (asynchronous, takes effect immediately on reset=1):
  - state=IDLE; byte_ready=0, busy=0, done=0, word_count=0.
  - byte index=0, assembly register=0, write pointer=0.
  - All memory words cleared to 32'h0000_0000, so chu=0 for every addr.
- States:
  - IDLE: start=1 with len!=0 -> LOAD; latch len_q=min(len, 2**ADDR_W); clear word_count, pointer and byte index. start=1 with len=0 -> DONE, word_count=0.
  - LOAD: byte_ready=1 and busy=1. start is ignored. A byte is accepted on a rising edge only when byte_valid && byte_ready. Accepted bytes fill the word MSB-first: byte 0 -> bits [31:24], byte 3 -> bits [7:0].
  - DONE: byte_ready=0, done=1, held indefinitely. start=1 behaves exactly as start in IDLE (restart); the memory is not cleared on restart.
- Word write, on the edge that accepts byte index 3:
  - mem[ptr] <= {b0,b1,b2,b3}; ptr++; word_count++; byte index returns to 0.
  - If the new word_count == len_q, move to DONE on the same edge. byte_ready is 0 from the next cycle on, and excess bytes are not accepted.
- byte_valid=0 gaps of any length stall assembly without losing partial bytes. byte_valid is ignored outside LOAD.
- Read port:
  - chu = mem[addr] purely combinational; no clock latency on read.
  - A written word is visible on chu the cycle after the write edge.
  - Reading the address being written in the same cycle returns the old value.
- Boundaries:
  - len > 2**ADDR_W is clamped; the pointer never wraps within one load.
  - len=2**ADDR_W fills addresses 0..1023 exactly.
  - reset during LOAD discards the partial word and clears the whole memory; state returns to IDLE.
  - start and byte_valid in the same IDLE cycle: the byte is not accepted (byte_ready=0 in IDLE).
- Widths: word_count and len_q are ADDR_W+1 bits; the pointer is ADDR_W bits; no other arithmetic.

Test Plan:
- Reset then sweep addr 0..1023 -> chu=0 everywhere; byte_ready=0, busy=0, done=0, word_count=0.
- start with len=2, then bytes 12 34 56 78 9A BC DE F0 back-to-back:
  - addr=0 -> chu=32'h12345678; addr=1 -> chu=32'h9ABCDEF0.
  - done=1 the cycle after the 8th accepted byte; word_count=2; byte_ready=0.
- Same stream with byte_valid deasserted for 3 cycles between each byte -> identical memory contents and word_count=2; busy stays 1 throughout.
- start with len=0 -> DONE on the next edge with done=1, word_count=0; memory unchanged.
- Load len=1 (AA BB CC), assert reset before the 4th byte -> state IDLE, addr=0 gives chu=0, byte_ready=0. Then start len=1 with 01 02 03 04 -> chu=32'h01020304.
- Restart from DONE: start len=1 with 11 22 33 44 after a prior 2-word load -> addr=0 gives 32'h11223344, addr=1 keeps 32'h9ABCDEF0, word_count=1.

Source files
------------

// File: rtl/im_loader.sv
// im_loader
// Loads a program into an internal instruction memory from a byte stream and
// exposes the same asynchronous read port as the instruction ROM
// (addr -> chu), so the CPU fetch path reads back whatever was loaded.
//
// Bytes arrive over a valid/ready handshake and are packed MSB-first into
// 32-bit words. Each finished word is written at an incrementing word
// address, starting from 0 on every load.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset (also clears the memory)
//   start       load request, honoured only in IDLE or DONE
//   len         number of words to load, sampled with start
//   byte_in     stream data byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  loader accepts a byte this cycle (LOAD only)
//   addr        read word address
//   chu         mem[addr], combinational
//   busy        high while loading
//   done        high once a load has finished
//   word_count  words written in the current or last load
module im_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       chu,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        byte_idx;
  // Holds bytes 0..2 of the word in progress; byte 3 goes straight from
  // byte_in into the memory write.
  logic [23:0]       asm_reg;
  logic              load_start;
  logic              accept;
  logic              word_write;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load that asks for more words than the memory holds is clamped, so the
  // write pointer can never wrap within one load.
  always_comb begin
    state_next  = state;
    byte_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    word_write  = 1'b0;
    load_start  = 1'b0;
    len_clamped = (len > DEPTH_W) ? DEPTH_W : len;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          load_start = 1'b1;
          state_next = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        accept     = byte_valid;
        if (accept && byte_idx == 2'd3) begin
          word_write = 1'b1;
          if (word_count + WC_ONE == len_q) begin
            state_next = S_DONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      word_count <= '0;
      ptr        <= '0;
      byte_idx   <= '0;
      asm_reg    <= '0;
    end else if (load_start) begin
      len_q      <= len_clamped;
      word_count <= '0;
      ptr        <= '0;
      byte_idx   <= '0;
      asm_reg    <= '0;
    end else if (accept) begin
      case (byte_idx)
        2'd0: asm_reg[23:16] <= byte_in;
        2'd1: asm_reg[15:8]  <= byte_in;
        2'd2: asm_reg[7:0]   <= byte_in;
        default: begin
          ptr        <= ptr + PTR_ONE;
          word_count <= word_count + WC_ONE;
        end
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Reset wipes every word so a reset mid-load leaves no stale program behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (word_write) begin
      mem[ptr] <= {asm_reg, byte_in};
    end
  end

  // Same-cycle read of the word being written returns the old contents.
  assign chu = mem[addr];

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader
// Directed bench for im_loader. Words are pushed to a scoreboard queue as
// their bytes are streamed in and popped/compared against chu once the load
// reports done. A shadow memory tracks words expected to stay untouched.
module tb_im_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       chu;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] stim_q[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad = 0;

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .addr       (addr),
    .chu        (chu),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Idle gap cycles first, then present one byte for exactly one edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      tick();
      checkOutput("busy_in_gap", 32'(busy), 32'd1);
    end
    checkOutput("byte_ready_in_load", 32'(byte_ready), 32'd1);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic startLoad(input int n);
    start = 1'b1;
    len   = n[ADDR_W:0];
    tick();
    start = 1'b0;
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      addr = e.a;
      #1;
      checkOutput($sformatf("chu_addr%0d", e.a), chu, e.d);
    end
  endtask

  task automatic checkDone(input int n);
    checkOutput("done_after_load", 32'(done), 32'd1);
    checkOutput("word_count_after_load", 32'(word_count), 32'(n));
    checkOutput("byte_ready_after_load", 32'(byte_ready), 32'd0);
    checkOutput("busy_after_load", 32'(busy), 32'd0);
  endtask

  // Streams n words from stim_q (clamped to the memory depth), pushing each
  // expected word to the scoreboard as its bytes are driven.
  task automatic loadWords(input int n, input int gap);
    int          eff;
    logic [31:0] word;
    eff = (n > DEPTH) ? DEPTH : n;
    startLoad(n);
    checkOutput("busy_on_entry", 32'(busy), 32'd1);
    for (int w = 0; w < eff; w++) begin
      word = stim_q.pop_front();
      sb_q.push_back({w[ADDR_W-1:0], word});
      model[w] = word;
      for (int k = 3; k >= 0; k--) begin
        applyStimulus(word[8*k +: 8], gap);
      end
      if (w == 0 && eff > 1) begin
        checkOutput("word_count_mid", 32'(word_count), 32'd1);
      end
    end
    checkDone(eff);
    drainScoreboard();
  endtask

  task automatic pushTwoWordStream();
    stim_q.push_back(32'h12345678);
    stim_q.push_back(32'h9ABCDEF0);
  endtask

  initial begin
    $display("[TB] start");
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset: outputs and the whole memory read as zero while reset is held.
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      addr = a[ADDR_W-1:0];
      #1;
      checkOutput("rst_chu_sweep", chu, 32'd0);
    end
    tick();
    reset = 1'b0;
    tick();

    // Two-word load, back-to-back bytes.
    pushTwoWordStream();
    loadWords(2, 0);

    // Excess bytes in DONE must be ignored.
    for (int i = 0; i < 4; i++) begin
      byte_in    = 8'hFF;
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    addr = 2;
    #1;
    checkOutput("excess_addr2", chu, 32'd0);
    checkOutput("excess_word_count", 32'(word_count), 32'd2);

    // Same stream with three-cycle gaps between bytes.
    pushTwoWordStream();
    loadWords(2, 3);

    // len=0 goes straight to DONE and leaves memory alone.
    startLoad(0);
    checkOutput("len0_done", 32'(done), 32'd1);
    checkOutput("len0_word_count", 32'(word_count), 32'd0);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    addr = 0;
    #1;
    checkOutput("len0_addr0", chu, model[0]);

    // Reset in the middle of a word.
    startLoad(1);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    applyStimulus(8'hCC, 0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    addr = 0;
    #1;
    checkOutput("midrst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_word_count", 32'(word_count), 32'd0);
    checkOutput("midrst_addr0", chu, 32'd0);
    addr = 1;
    #1;
    checkOutput("midrst_addr1", chu, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // start and byte_valid in the same IDLE cycle: the byte is dropped.
    start      = 1'b1;
    len        = 1;
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    tick();
    start      = 1'b0;
    byte_valid = 1'b0;
    sb_q.push_back({ADDR_W'(0), 32'h01020304});
    model[0] = 32'h01020304;
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    applyStimulus(8'h04, 0);
    checkDone(1);
    drainScoreboard();

    // Restart from DONE after a two-word load keeps the untouched word.
    pushTwoWordStream();
    loadWords(2, 0);
    stim_q.push_back(32'h11223344);
    loadWords(1, 0);
    addr = 1;
    #1;
    checkOutput("restart_addr1_kept", chu, 32'h9ABCDEF0);

    // Oversized len is clamped to the full depth; pointer must not wrap.
    for (int i = 0; i < DEPTH; i++) stim_q.push_back($urandom);
    loadWords(1500, 0);
    for (int i = 0; i < 4; i++) begin
      byte_in    = 8'h5A;
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    addr = 0;
    #1;
    checkOutput("clamp_no_wrap_addr0", chu, model[0]);
    checkOutput("clamp_word_count", 32'(word_count), 32'(DEPTH));
    checkOutput("clamp_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
